vertex_pe_scheduler: RTL and testbench

VERTEX_PE_SCHEDULER -- requirements
Module: vertex_pe_scheduler

---
 rtl/sched_pkg.sv | 22 ++
 rtl/sched_result_fifo.sv | 56 +++++
 rtl/vertex_pe_scheduler.sv | 153 +++++++++++++++
 tb/tb_vertex_pe_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and widths for the Vertex PE scheduler: state encoding plus the
// feature-vector / node-id sizing macros used across the PE datapath.
`ifndef FV_size
`define FV_size 16
`endif
`ifndef Max_Node_id
`define Max_Node_id 64
`endif
`ifndef Mult_per_PE
`define Mult_per_PE 2
`endif

package sched_pkg;
  localparam int FV_W = `FV_size;
  localparam int ID_W = $clog2(`Max_Node_id);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;
endpackage

// File: rtl/sched_result_fifo.sv
// Result buffer between the PE output and the consumer; holds value + node id.
// DEPTH must be a power of two so the pointers wrap naturally.
module sched_result_fifo
  import sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [FV_W-1:0]          push_data,
  input  logic [ID_W-1:0]          push_id,
  input  logic                     pop,
  output logic [FV_W-1:0]          pop_data,
  output logic [ID_W-1:0]          pop_id,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [FV_W+ID_W-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so nothing stale is visible on the outputs.
  assign {pop_data, pop_id} = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_data, push_id};
  end
endmodule

// File: rtl/vertex_pe_scheduler.sv
// Round-robin front end for one shared Vertex PE: arbitrates requesters, drives
// registered PE operands and buffers PE results for a ready/valid consumer.
module vertex_pe_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sched_en,
  input  logic                      cfg_we,
  input  logic [FV_W-1:0]           cfg_weight_0,
  input  logic [FV_W-1:0]           cfg_weight_1,
  output logic                      cfg_err,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FV_W-1:0]   req_fv_0,
  input  logic [NUM_REQ*FV_W-1:0]   req_fv_1,
  input  logic [NUM_REQ*ID_W-1:0]   req_node_id,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [FV_W-1:0]           pe_fv_0,
  output logic [FV_W-1:0]           pe_fv_1,
  output logic [FV_W-1:0]           pe_weight_0,
  output logic [FV_W-1:0]           pe_weight_1,
  output logic [ID_W-1:0]           pe_node_id,
  input  logic [FV_W-1:0]           pe_vertex_out,
  input  logic [ID_W-1:0]           pe_node_id_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FV_W-1:0]           out_data,
  output logic [ID_W-1:0]           out_node_id,
  output logic                      busy
);
  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t                  state;
  sched_state_t                  state_nxt;
  logic                          run_st;
  logic [RR_W-1:0]               rr_ptr;
  logic [RR_W-1:0]               grant_idx;
  logic                          grant_found;
  logic                          issue_ok;
  logic                          issue;
  logic                          vld_p1;
  logic [FV_W-1:0]               weight_0;
  logic [FV_W-1:0]               weight_1;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(OFIFO_DEPTH):0]  fifo_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sched_en) state_nxt = RUN;
      RUN:     if (!sched_en) state_nxt = DRAIN;
      DRAIN: begin
        if (sched_en)                     state_nxt = RUN;
        else if (!vld_p1 && fifo_empty)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    run_st = (state == RUN);
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = RR_W'(idx);
      end
    end
  end

  // The PE cannot stall, so every issue must already own a FIFO slot.
  assign issue_ok = run_st && !fifo_full &&
                    ((int'(fifo_count) + int'(vld_p1)) < OFIFO_DEPTH);
  assign issue    = issue_ok && grant_found;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weight_0 <= '0;
      weight_1 <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (state != IDLE);
      if (cfg_we && (state == IDLE)) begin
        weight_0 <= cfg_weight_0;
        weight_1 <= cfg_weight_1;
      end
    end
  end

  // Stage p0 -> p1: grant edge registers operands onto the PE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      vld_p1      <= 1'b0;
      pe_fv_0     <= '0;
      pe_fv_1     <= '0;
      pe_weight_0 <= '0;
      pe_weight_1 <= '0;
      pe_node_id  <= '0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        rr_ptr      <= (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        pe_fv_0     <= req_fv_0[int'(grant_idx)*FV_W +: FV_W];
        pe_fv_1     <= req_fv_1[int'(grant_idx)*FV_W +: FV_W];
        pe_weight_0 <= weight_0;
        pe_weight_1 <= weight_1;
        pe_node_id  <= req_node_id[int'(grant_idx)*ID_W +: ID_W];
      end
    end
  end

  // Stage p1 -> FIFO: PE result captured one edge after issue
  sched_result_fifo #(
    .DEPTH (OFIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p1),
    .push_data (pe_vertex_out),
    .push_id   (pe_node_id_out),
    .pop       (out_valid && out_ready),
    .pop_data  (out_data),
    .pop_id    (out_node_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
endmodule

// File: tb/tb_vertex_pe_scheduler.sv
// Bench for vertex_pe_scheduler: directed scenarios plus a random phase, all
// checked every cycle against a queue-based model of the scheduler.
module tb_vertex_pe_scheduler;
  localparam int NR      = 4;
  localparam int DEPTH   = 4;
  localparam int FW      = sched_pkg::FV_W;
  localparam int IW      = sched_pkg::ID_W;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic              clk;
  logic              reset;
  logic              sched_en;
  logic              cfg_we;
  logic [FW-1:0]     cfg_weight_0;
  logic [FW-1:0]     cfg_weight_1;
  logic              cfg_err;
  logic [NR-1:0]     req_valid;
  logic [NR*FW-1:0]  req_fv_0;
  logic [NR*FW-1:0]  req_fv_1;
  logic [NR*IW-1:0]  req_node_id;
  logic [NR-1:0]     req_ready;
  logic [FW-1:0]     pe_fv_0;
  logic [FW-1:0]     pe_fv_1;
  logic [FW-1:0]     pe_weight_0;
  logic [FW-1:0]     pe_weight_1;
  logic [IW-1:0]     pe_node_id;
  logic [FW-1:0]     pe_vertex_out;
  logic [IW-1:0]     pe_node_id_out;
  logic              out_valid;
  logic              out_ready;
  logic [FW-1:0]     out_data;
  logic [IW-1:0]     out_node_id;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  vertex_pe_scheduler #(.NUM_REQ(NR), .OFIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .sched_en       (sched_en),
    .cfg_we         (cfg_we),
    .cfg_weight_0   (cfg_weight_0),
    .cfg_weight_1   (cfg_weight_1),
    .cfg_err        (cfg_err),
    .req_valid      (req_valid),
    .req_fv_0       (req_fv_0),
    .req_fv_1       (req_fv_1),
    .req_node_id    (req_node_id),
    .req_ready      (req_ready),
    .pe_fv_0        (pe_fv_0),
    .pe_fv_1        (pe_fv_1),
    .pe_weight_0    (pe_weight_0),
    .pe_weight_1    (pe_weight_1),
    .pe_node_id     (pe_node_id),
    .pe_vertex_out  (pe_vertex_out),
    .pe_node_id_out (pe_node_id_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_node_id    (out_node_id),
    .busy           (busy)
  );

  function automatic logic [FW-1:0] pe_math(input logic [FW-1:0] a0, input logic [FW-1:0] b0,
                                            input logic [FW-1:0] a1, input logic [FW-1:0] b1);
    logic [63:0] p;
    p = 64'(a0) * 64'(b0) + 64'(a1) * 64'(b1);
    return p[FW-1:0];
  endfunction

  // Combinational stand-in for the Vertex PE.
  assign pe_vertex_out  = pe_math(pe_fv_0, pe_weight_0, pe_fv_1, pe_weight_1);
  assign pe_node_id_out = pe_node_id;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [FW-1:0] data;
    logic [IW-1:0] id;
  } res_t;

  res_t          m_fifo[$];
  res_t          m_pipe[$];
  int            m_mode;
  int            m_rr;
  logic [FW-1:0] m_w0, m_w1;
  logic [FW-1:0] m_pe_fv0, m_pe_fv1, m_pe_w0, m_pe_w1;
  logic [IW-1:0] m_pe_id;
  bit            m_cfg_err;

  task automatic m_reset();
    m_fifo.delete();
    m_pipe.delete();
    m_mode = M_IDLE;
    m_rr = 0;
    m_w0 = '0; m_w1 = '0;
    m_pe_fv0 = '0; m_pe_fv1 = '0; m_pe_w0 = '0; m_pe_w1 = '0; m_pe_id = '0;
    m_cfg_err = 1'b0;
  endtask

  function automatic int m_pick();
    int i;
    if (m_mode != M_RUN) return -1;
    if (m_fifo.size() + m_pipe.size() >= DEPTH) return -1;
    for (int k = 0; k < NR; k++) begin
      i = (m_rr + k) % NR;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_advance();
    int   g;
    bit   pre_empty;
    res_t r;
    g = m_pick();
    pre_empty = (m_fifo.size() == 0) && (m_pipe.size() == 0);
    if (m_fifo.size() != 0 && out_ready) void'(m_fifo.pop_front());
    if (m_pipe.size() != 0) m_fifo.push_back(m_pipe.pop_front());
    if (g >= 0) begin
      m_pe_fv0 = req_fv_0[g*FW +: FW];
      m_pe_fv1 = req_fv_1[g*FW +: FW];
      m_pe_w0  = m_w0;
      m_pe_w1  = m_w1;
      m_pe_id  = req_node_id[g*IW +: IW];
      r.data   = pe_math(m_pe_fv0, m_w0, m_pe_fv1, m_w1);
      r.id     = m_pe_id;
      m_pipe.push_back(r);
      m_rr = (g + 1) % NR;
    end
    m_cfg_err = cfg_we && (m_mode != M_IDLE);
    if (cfg_we && m_mode == M_IDLE) begin
      m_w0 = cfg_weight_0;
      m_w1 = cfg_weight_1;
    end
    case (m_mode)
      M_IDLE:  if (sched_en) m_mode = M_RUN;
      M_RUN:   if (!sched_en) m_mode = M_DRAIN;
      default: begin
        if (sched_en)       m_mode = M_RUN;
        else if (pre_empty) m_mode = M_IDLE;
      end
    endcase
  endtask

  int            cmp_g;
  logic [NR-1:0] cmp_ev;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) m_reset();
      cmp_g  = m_pick();
      cmp_ev = '0;
      if (cmp_g >= 0) cmp_ev[cmp_g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(cmp_ev));
      chk("out_valid", 64'(out_valid), 64'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
        chk("out_data", 64'(out_data), 64'(m_fifo[0].data));
        chk("out_node_id", 64'(out_node_id), 64'(m_fifo[0].id));
      end
      chk("busy", 64'(busy), 64'(m_mode != M_IDLE));
      chk("cfg_err", 64'(cfg_err), 64'(m_cfg_err));
      chk("pe_fv_0", 64'(pe_fv_0), 64'(m_pe_fv0));
      chk("pe_fv_1", 64'(pe_fv_1), 64'(m_pe_fv1));
      chk("pe_weight_0", 64'(pe_weight_0), 64'(m_pe_w0));
      chk("pe_weight_1", 64'(pe_weight_1), 64'(m_pe_w1));
      chk("pe_node_id", 64'(pe_node_id), 64'(m_pe_id));
      if (reset) m_advance();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int fv0, input int fv1, input int id);
    req_fv_0[i*FW +: FW]    = FW'(fv0);
    req_fv_1[i*FW +: FW]    = FW'(fv1);
    req_node_id[i*IW +: IW] = IW'(id);
  endtask

  logic [NR-1:0] gseq [5];
  logic [IW-1:0] oseq [5];

  initial begin
    int ng, no, n, d;
    bit ok, seen;
    reset = 1'b0; sched_en = 1'b0; cfg_we = 1'b0;
    cfg_weight_0 = '0; cfg_weight_1 = '0;
    req_valid = '0; req_fv_0 = '0; req_fv_1 = '0; req_node_id = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_pe_weight_0", 64'(pe_weight_0), 64'd0);
    step();
    reset = 1'b1;

    // Weights 3,5 loaded while idle
    cfg_we = 1'b1; cfg_weight_0 = FW'(3); cfg_weight_1 = FW'(5);
    step();
    cfg_we = 1'b0;
    step();

    // Round-robin order with all requesters valid
    for (int i = 0; i < NR; i++) set_req(i, i + 1, i + 2, 10 + i);
    req_valid = '1; out_ready = 1'b1; sched_en = 1'b1;
    ng = 0; no = 0;
    for (int c = 0; c < 40 && no < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0 && ng < 5) begin gseq[ng] = req_ready; ng++; end
      if (out_valid && out_ready && no < 5) begin oseq[no] = out_node_id; no++; end
      step();
      if (ng >= 5) req_valid = '0;
    end
    chk("rr_grant_count", 64'(ng), 64'd5);
    chk("rr_out_count", 64'(no), 64'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant_%0d", k), 64'(gseq[k]), 64'(4'b0001 << (k % 4)));
      chk($sformatf("rr_out_id_%0d", k), 64'(oseq[k]), 64'(10 + (k % 4)));
    end

    // Requester 2: 2*3 + 4*5 = 26, id 7
    set_req(2, 2, 4, 7);
    req_valid = 4'b0100;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready != 4'b0100 && n < 10);
    chk("compute_grant", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 10);
    chk("compute_latency", 64'(n), 64'd2);
    chk("compute_data", 64'(out_data), 64'd26);
    chk("compute_id", 64'(out_node_id), 64'd7);

    // Weight write while running is rejected
    step();
    cfg_we = 1'b1; cfg_weight_0 = FW'(9); cfg_weight_1 = FW'(9);
    step();
    cfg_we = 1'b0;
    @(negedge clk);
    chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
    @(negedge clk);
    chk("cfg_err_clear", 64'(cfg_err), 64'd0);
    step();
    set_req(1, 1, 1, 3);
    req_valid = 4'b0010;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready != 4'b0010 && n < 10);
    chk("guard_grant", 64'(req_ready), 64'(4'b0010));
    step();
    req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 10);
    chk("guard_data", 64'(out_data), 64'd8);
    chk("guard_id", 64'(out_node_id), 64'd3);
    chk("guard_weight_0", 64'(pe_weight_0), 64'd3);

    // Back-pressure: capacity of four, then one pop buys one grant
    step();
    out_ready = 1'b0; req_valid = '1;
    ng = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready != '0) ng++;
    end
    chk("bp_grants", 64'(ng), 64'd4);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready != '0) ng++;
    end
    chk("bp_regrant", 64'(ng), 64'd1);
    step();
    out_ready = 1'b1; req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (out_valid && n < 20);
    chk("bp_emptied", 64'(out_valid), 64'd0);

    // Drain with two results outstanding
    step();
    out_ready = 1'b0; req_valid = 4'b0011;
    ng = 0; n = 0;
    do begin
      @(negedge clk); n++;
      if (req_ready != '0) ng++;
    end while (ng < 2 && n < 20);
    step();
    sched_en = 1'b0; req_valid = '0;
    step();
    req_valid = '1;
    ng = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req_ready != '0) ng++;
    end
    chk("drain_no_grant", 64'(ng), 64'd0);
    chk("drain_busy", 64'(busy), 64'd1);
    step();
    out_ready = 1'b1;
    d = 0; seen = 1'b0; n = 0;
    do begin
      @(negedge clk); n++;
      if (out_valid && out_ready) d++;
      if (!out_valid && busy) seen = 1'b1;
    end while (busy && n < 20);
    chk("drain_delivered", 64'(d), 64'd2);
    chk("drain_busy_after_empty", 64'(seen), 64'd1);
    chk("drain_idle", 64'(busy), 64'd0);
    step();
    req_valid = '0;

    // Reset the cycle after a grant
    sched_en = 1'b1; req_valid = 4'b0001; set_req(0, 5, 6, 9);
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == '0 && n < 10);
    chk("rst_mid_grant", 64'(req_ready), 64'(4'b0001));
    step();
    reset = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_pe_fv_0", 64'(pe_fv_0), 64'd0);
    chk("rst_mid_pe_node_id", 64'(pe_node_id), 64'd0);
    chk("rst_mid_out_data", 64'(out_data), 64'd0);
    step();
    reset = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b0;
    end
    chk("rst_no_stale", 64'(ok), 64'd1);

    // Random traffic
    step();
    sched_en = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 20);
    chk("rand_pre_idle", 64'(busy), 64'd0);
    step();
    cfg_we = 1'b1; cfg_weight_0 = FW'($urandom); cfg_weight_1 = FW'($urandom);
    step();
    cfg_we = 1'b0; sched_en = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      step();
      reset = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 31) == 0) sched_en = ~sched_en;
      cfg_we = ($urandom_range(0, 11) == 0);
      cfg_weight_0 = FW'($urandom);
      cfg_weight_1 = FW'($urandom);
      req_valid = NR'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) set_req(i, int'($urandom), int'($urandom), int'($urandom));
    end
    step();
    reset = 1'b1; req_valid = '0; cfg_we = 1'b0; sched_en = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
